// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - stall/forward controller owning the producer pipeline and md busy countdown
module hazard_scoreboard #(
    parameter int NUM_STAGES = 2,
    parameter int TW         = 2,
    parameter int MUL_LAT    = 5,
    parameter int DIV_LAT    = 10,
    parameter int EPC_ADDR   = 14,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             isRead_Rs_D,
    input  logic [4:0]       Rs_D,
    input  logic [TW-1:0]    Tuse_Rs_D,
    input  logic             isRead_Rt_D,
    input  logic [4:0]       Rt_D,
    input  logic [TW-1:0]    Tuse_Rt_D,
    input  logic [4:0]       A3_D,
    input  logic [TW-1:0]    Tnew_D,
    input  logic             isMDStart_D,
    input  logic             isDiv_D,
    input  logic             isMDFT_D,
    input  logic             isEret_D,
    input  logic             ismtc0_D,
    input  logic [4:0]       Rd_D,
    input  logic             req_flush,
    output logic             stallPC,
    output logic             stallID,
    output logic             flushEX,
    output logic [2:0]       fwd_rs_sel,
    output logic [2:0]       fwd_rt_sel,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int MD_MAX = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int MD_W   = $clog2(MD_MAX + 1);

    logic [4:0]            a3_q   [NUM_STAGES];
    logic [4:0]            a3_d   [NUM_STAGES];
    logic [TW-1:0]         tnew_q [NUM_STAGES];
    logic [TW-1:0]         tnew_d [NUM_STAGES];
    logic [NUM_STAGES-1:0] epc_q;
    logic [NUM_STAGES-1:0] epc_d;
    logic [MD_W-1:0]       md_cnt_q;
    logic [MD_W-1:0]       md_cnt_d;
    logic [CNT_W-1:0]      stall_cnt_q;
    logic [CNT_W-1:0]      stall_cnt_d;

    logic rs_clash;
    logic rt_clash;
    logic md_clash;
    logic eret_clash;
    logic stall;
    logic stall_out;

    always_comb begin
        rs_clash   = 1'b0;
        rt_clash   = 1'b0;
        eret_clash = 1'b0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (isRead_Rs_D && (Rs_D == a3_q[k]) && (a3_q[k] != 5'd0) && (Tuse_Rs_D < tnew_q[k]))
                rs_clash = 1'b1;
            if (isRead_Rt_D && (Rt_D == a3_q[k]) && (a3_q[k] != 5'd0) && (Tuse_Rt_D < tnew_q[k]))
                rt_clash = 1'b1;
            if (isEret_D && epc_q[k])
                eret_clash = 1'b1;
        end
    end

    assign md_busy   = (md_cnt_q != '0);
    assign md_clash  = (isMDFT_D | isMDStart_D) & md_busy;
    assign stall     = rs_clash | rt_clash | md_clash | eret_clash;
    assign stall_out = stall & ~req_flush;
    assign stallPC   = stall_out;
    assign stallID   = stall_out;
    assign flushEX   = stall_out;
    assign stall_cnt = stall_cnt_q;

    // Walk oldest to youngest so the youngest matching producer decides; a
    // younger match that is not ready yet masks any older ready copy.
    always_comb begin
        fwd_rs_sel = 3'd0;
        fwd_rt_sel = 3'd0;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if ((Rs_D == a3_q[k]) && (a3_q[k] != 5'd0))
                fwd_rs_sel = (tnew_q[k] == '0) ? 3'(k + 1) : 3'd0;
            if ((Rt_D == a3_q[k]) && (a3_q[k] != 5'd0))
                fwd_rt_sel = (tnew_q[k] == '0) ? 3'(k + 1) : 3'd0;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_STAGES; k++) begin
            a3_d[k]   = a3_q[k];
            tnew_d[k] = tnew_q[k];
        end
        epc_d       = epc_q;
        md_cnt_d    = md_cnt_q;
        stall_cnt_d = stall_cnt_q;

        if (req_flush) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                a3_d[k]   = 5'd0;
                tnew_d[k] = '0;
            end
            epc_d    = '0;
            md_cnt_d = '0;
        end else begin
            for (int k = 1; k < NUM_STAGES; k++) begin
                a3_d[k]   = a3_q[k-1];
                tnew_d[k] = (tnew_q[k-1] != '0) ? (tnew_q[k-1] - TW'(1)) : '0;
                epc_d[k]  = epc_q[k-1];
            end
            a3_d[0]   = stall ? 5'd0 : A3_D;
            tnew_d[0] = stall ? '0 : Tnew_D;
            epc_d[0]  = ~stall & ismtc0_D & (Rd_D == 5'(EPC_ADDR));

            // Counting from issue lets the very next D instruction see busy.
            if (isMDStart_D && !stall)
                md_cnt_d = isDiv_D ? MD_W'(DIV_LAT) : MD_W'(MUL_LAT);
            else if (md_cnt_q != '0)
                md_cnt_d = md_cnt_q - MD_W'(1);
        end

        if (stall_out && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                a3_q[k]   <= 5'd0;
                tnew_q[k] <= '0;
            end
            epc_q       <= '0;
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                a3_q[k]   <= a3_d[k];
                tnew_q[k] <= tnew_d[k];
            end
            epc_q       <= epc_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed scenarios plus randomized check against an issue-history model
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        isRead_Rs_D, isRead_Rt_D;
    logic [4:0]  Rs_D, Rt_D, A3_D, Rd_D;
    logic [1:0]  Tuse_Rs_D, Tuse_Rt_D, Tnew_D;
    logic        isMDStart_D, isDiv_D, isMDFT_D, isEret_D, ismtc0_D, req_flush;
    logic        stallPC, stallID, flushEX, md_busy;
    logic [2:0]  fwd_rs_sel, fwd_rt_sel;
    logic [31:0] stall_cnt;
    logic        s3_stallPC, s3_stallID, s3_flushEX, s3_md_busy;
    logic [2:0]  s3_fwd_rs_sel, s3_fwd_rt_sel;
    logic [1:0]  s3_stall_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hazard_scoreboard u_dut (
        .clk(clk), .rst_n(rst_n),
        .isRead_Rs_D(isRead_Rs_D), .Rs_D(Rs_D), .Tuse_Rs_D(Tuse_Rs_D),
        .isRead_Rt_D(isRead_Rt_D), .Rt_D(Rt_D), .Tuse_Rt_D(Tuse_Rt_D),
        .A3_D(A3_D), .Tnew_D(Tnew_D), .isMDStart_D(isMDStart_D), .isDiv_D(isDiv_D),
        .isMDFT_D(isMDFT_D), .isEret_D(isEret_D), .ismtc0_D(ismtc0_D), .Rd_D(Rd_D),
        .req_flush(req_flush), .stallPC(stallPC), .stallID(stallID), .flushEX(flushEX),
        .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    hazard_scoreboard #(.NUM_STAGES(3), .CNT_W(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .isRead_Rs_D(isRead_Rs_D), .Rs_D(Rs_D), .Tuse_Rs_D(Tuse_Rs_D),
        .isRead_Rt_D(isRead_Rt_D), .Rt_D(Rt_D), .Tuse_Rt_D(Tuse_Rt_D),
        .A3_D(A3_D), .Tnew_D(Tnew_D), .isMDStart_D(isMDStart_D), .isDiv_D(isDiv_D),
        .isMDFT_D(isMDFT_D), .isEret_D(isEret_D), .ismtc0_D(ismtc0_D), .Rd_D(Rd_D),
        .req_flush(req_flush), .stallPC(s3_stallPC), .stallID(s3_stallID), .flushEX(s3_flushEX),
        .fwd_rs_sel(s3_fwd_rs_sel), .fwd_rt_sel(s3_fwd_rt_sel), .md_busy(s3_md_busy),
        .stall_cnt(s3_stall_cnt)
    );

    // Reference model: remembers what issued each cycle; slot k holds the
    // instruction issued k+1 cycles ago unless it stalled or a flush came since.
    int   mcyc, last_flush, md_end, e_cnt;
    bit   hv  [16];
    int   ha3 [16];
    int   htn [16];
    bit   hep [16];
    bit   e_stall, e_raw, e_busy;
    int   e_fwd_rs, e_fwd_rt;

    task automatic nop();
        isRead_Rs_D = 0; Rs_D = 0; Tuse_Rs_D = 0;
        isRead_Rt_D = 0; Rt_D = 0; Tuse_Rt_D = 0;
        A3_D = 0; Tnew_D = 0; isMDStart_D = 0; isDiv_D = 0; isMDFT_D = 0;
        isEret_D = 0; ismtc0_D = 0; Rd_D = 0; req_flush = 0;
    endtask

    task automatic do_reset();
        nop();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mcyc = 100; last_flush = 99; md_end = 99; e_cnt = 0;
        for (int i = 0; i < 16; i++) hv[i] = 0;
    endtask

    task automatic model_eval();
        int c, a, tn;
        bit m_rs, m_rt, st;
        st = 0; m_rs = 0; m_rt = 0; e_fwd_rs = 0; e_fwd_rt = 0;
        for (int k = 0; k < 2; k++) begin
            c = mcyc - 1 - k;
            if (c > last_flush && hv[c % 16]) begin
                a  = ha3[c % 16];
                tn = htn[c % 16] - k;
                if (tn < 0) tn = 0;
                if (a != 0) begin
                    if (isRead_Rs_D && int'(Rs_D) == a && int'(Tuse_Rs_D) < tn) st = 1;
                    if (isRead_Rt_D && int'(Rt_D) == a && int'(Tuse_Rt_D) < tn) st = 1;
                    if (!m_rs && int'(Rs_D) == a) begin m_rs = 1; e_fwd_rs = (tn == 0) ? k + 1 : 0; end
                    if (!m_rt && int'(Rt_D) == a) begin m_rt = 1; e_fwd_rt = (tn == 0) ? k + 1 : 0; end
                end
                if (isEret_D && hep[c % 16]) st = 1;
            end
        end
        e_busy = (mcyc <= md_end);
        if ((isMDFT_D || isMDStart_D) && e_busy) st = 1;
        e_raw   = st;
        e_stall = st && !req_flush;
    endtask

    task automatic model_clock();
        if (req_flush) begin
            last_flush = mcyc;
            md_end     = mcyc;
        end else begin
            hv[mcyc % 16]  = !e_raw;
            ha3[mcyc % 16] = int'(A3_D);
            htn[mcyc % 16] = int'(Tnew_D);
            hep[mcyc % 16] = ismtc0_D && (Rd_D == 5'd14);
            if (isMDStart_D && !e_raw) md_end = mcyc + (isDiv_D ? 10 : 5);
        end
        if (e_stall) e_cnt++;
        mcyc++;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        tests++; if (stallPC !== 1'b0) begin fails++; $display("FAIL reset_stallPC got %b want 0", stallPC); end
        tests++; if (fwd_rs_sel !== 3'd0 || fwd_rt_sel !== 3'd0) begin fails++; $display("FAIL reset_fwd got %0d/%0d want 0/0", fwd_rs_sel, fwd_rt_sel); end
        tests++; if (md_busy !== 1'b0) begin fails++; $display("FAIL reset_md_busy got %b want 0", md_busy); end
        tests++; if (stall_cnt !== 32'd0) begin fails++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
        next_cycle();
    endtask

    task automatic test_load_use();
        do_reset();
        A3_D = 1; Tnew_D = 1;
        @(negedge clk);
        tests++; if (stallPC !== 1'b0) begin fails++; $display("FAIL lu_issue stallPC got %b want 0", stallPC); end
        next_cycle(); nop();
        isRead_Rs_D = 1; Rs_D = 1; isRead_Rt_D = 1; Rt_D = 1; A3_D = 2;
        @(negedge clk);
        tests++; if ({stallPC, stallID, flushEX} !== 3'b111) begin fails++; $display("FAIL lu_stall got %b want 111", {stallPC, stallID, flushEX}); end
        next_cycle();
        @(negedge clk);
        tests++; if (stallPC !== 1'b0) begin fails++; $display("FAIL lu_release stallPC got %b want 0", stallPC); end
        tests++; if (fwd_rs_sel !== 3'd2 || fwd_rt_sel !== 3'd2) begin fails++; $display("FAIL lu_fwd got %0d/%0d want 2/2", fwd_rs_sel, fwd_rt_sel); end
        tests++; if (stall_cnt !== 32'd1) begin fails++; $display("FAIL lu_cnt got %0d want 1", stall_cnt); end
        next_cycle();
    endtask

    task automatic test_alu_fwd();
        do_reset();
        A3_D = 3; Tnew_D = 0;
        next_cycle(); nop();
        isRead_Rs_D = 1; Rs_D = 3; A3_D = 0; Tnew_D = 3;
        @(negedge clk);
        tests++; if (stallPC !== 1'b0 || fwd_rs_sel !== 3'd1) begin fails++; $display("FAIL alu_fwd got stall=%b fwd=%0d want 0/1", stallPC, fwd_rs_sel); end
        next_cycle(); nop();
        isRead_Rs_D = 1; Rs_D = 0; isRead_Rt_D = 1; Rt_D = 0;
        @(negedge clk);
        tests++; if (stallPC !== 1'b0 || fwd_rs_sel !== 3'd0 || fwd_rt_sel !== 3'd0) begin
            fails++; $display("FAIL zero_dest got stall=%b fwd=%0d/%0d want 0/0/0", stallPC, fwd_rs_sel, fwd_rt_sel); end
        next_cycle();
    endtask

    task automatic test_md();
        do_reset();
        isMDStart_D = 1; isDiv_D = 1;
        @(negedge clk);
        tests++; if (stallPC !== 1'b0) begin fails++; $display("FAIL div_issue stallPC got %b want 0", stallPC); end
        next_cycle(); nop(); isMDFT_D = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests++; if (stallPC !== 1'b1 || md_busy !== 1'b1) begin fails++; $display("FAIL div_wait%0d got stall=%b busy=%b want 1/1", i, stallPC, md_busy); end
            next_cycle();
        end
        @(negedge clk);
        tests++; if (stallPC !== 1'b0 || md_busy !== 1'b0 || stall_cnt !== 32'd10) begin
            fails++; $display("FAIL div_done got stall=%b busy=%b cnt=%0d want 0/0/10", stallPC, md_busy, stall_cnt); end
        next_cycle(); nop(); isMDStart_D = 1;
        next_cycle(); nop(); isMDFT_D = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++; if (stallPC !== 1'b1) begin fails++; $display("FAIL mul_wait%0d got %b want 1", i, stallPC); end
            next_cycle();
        end
        @(negedge clk);
        tests++; if (stallPC !== 1'b0 || stall_cnt !== 32'd15) begin fails++; $display("FAIL mul_done got stall=%b cnt=%0d want 0/15", stallPC, stall_cnt); end
        next_cycle();
    endtask

    task automatic test_eret();
        do_reset();
        ismtc0_D = 1; Rd_D = 14;
        next_cycle(); nop(); isEret_D = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests++; if (stallPC !== 1'b1) begin fails++; $display("FAIL eret_wait%0d got %b want 1", i, stallPC); end
            next_cycle();
        end
        @(negedge clk);
        tests++; if (stallPC !== 1'b0) begin fails++; $display("FAIL eret_go got %b want 0", stallPC); end
        next_cycle(); nop(); ismtc0_D = 1; Rd_D = 12;
        next_cycle(); nop(); isEret_D = 1;
        @(negedge clk);
        tests++; if (stallPC !== 1'b0 || stall_cnt !== 32'd2) begin fails++; $display("FAIL eret_other got stall=%b cnt=%0d want 0/2", stallPC, stall_cnt); end
        next_cycle();
    endtask

    task automatic test_flush();
        do_reset();
        isMDStart_D = 1; isDiv_D = 1;
        next_cycle(); nop(); A3_D = 1; Tnew_D = 1;
        next_cycle(); nop(); isRead_Rs_D = 1; Rs_D = 1; isMDFT_D = 1; req_flush = 1;
        @(negedge clk);
        tests++; if ({stallPC, stallID, flushEX} !== 3'b000 || md_busy !== 1'b1) begin
            fails++; $display("FAIL flush_cycle got stall=%b busy=%b want 000/1", {stallPC, stallID, flushEX}, md_busy); end
        next_cycle(); req_flush = 0;
        @(negedge clk);
        tests++; if (stallPC !== 1'b0 || md_busy !== 1'b0 || fwd_rs_sel !== 3'd0 || stall_cnt !== 32'd0) begin
            fails++; $display("FAIL flush_after got stall=%b busy=%b fwd=%0d cnt=%0d want 0/0/0/0", stallPC, md_busy, fwd_rs_sel, stall_cnt); end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        A3_D = 1; Tnew_D = 3;
        next_cycle(); nop(); isRead_Rs_D = 1; Rs_D = 1;
        next_cycle();
        @(negedge clk);
        tests++; if (stallPC !== 1'b1 || stall_cnt !== 32'd1) begin fails++; $display("FAIL mid_pre got stall=%b cnt=%0d want 1/1", stallPC, stall_cnt); end
        #1 rst_n = 1'b0;
        #1;
        tests++; if (stallPC !== 1'b0 || stall_cnt !== 32'd0) begin fails++; $display("FAIL mid_rst got stall=%b cnt=%0d want 0/0", stallPC, stall_cnt); end
        next_cycle(); rst_n = 1'b1; nop();
    endtask

    task automatic test_ns3();
        do_reset();
        A3_D = 5; Tnew_D = 2;
        next_cycle(); nop();
        next_cycle();
        @(negedge clk);
        Rs_D = 5; #0;
        next_cycle(); isRead_Rs_D = 1; Rs_D = 5; Tuse_Rs_D = 3;
        @(negedge clk);
        tests++; if (s3_fwd_rs_sel !== 3'd3 || s3_stallPC !== 1'b0) begin fails++; $display("FAIL ns3_fwd got fwd=%0d stall=%b want 3/0", s3_fwd_rs_sel, s3_stallPC); end
        tests++; if (fwd_rs_sel !== 3'd0) begin fails++; $display("FAIL ns2_gone got %0d want 0", fwd_rs_sel); end
        next_cycle(); nop(); isMDStart_D = 1; isDiv_D = 1;
        next_cycle(); nop(); isMDFT_D = 1;
        repeat (10) next_cycle();
        @(negedge clk);
        tests++; if (s3_stall_cnt !== 2'd3 || stall_cnt !== 32'd10) begin fails++; $display("FAIL sat_cnt got %0d/%0d want 3/10", s3_stall_cnt, stall_cnt); end
        next_cycle();
    endtask

    task automatic test_random();
        do_reset();
        model_reset();
        for (int n = 0; n < 400; n++) begin
            Rs_D = 5'($urandom_range(0, 3)); Rt_D = 5'($urandom_range(0, 3)); A3_D = 5'($urandom_range(0, 3));
            Tuse_Rs_D = 2'($urandom_range(0, 3)); Tuse_Rt_D = 2'($urandom_range(0, 3)); Tnew_D = 2'($urandom_range(0, 3));
            isRead_Rs_D = 1'($urandom_range(0, 1)); isRead_Rt_D = 1'($urandom_range(0, 1));
            isMDStart_D = ($urandom_range(0, 5) == 0); isDiv_D = 1'($urandom_range(0, 1));
            isMDFT_D = ($urandom_range(0, 5) == 0); isEret_D = ($urandom_range(0, 7) == 0);
            ismtc0_D = ($urandom_range(0, 3) == 0); Rd_D = ($urandom_range(0, 1) == 0) ? 5'd14 : 5'd12;
            req_flush = ($urandom_range(0, 15) == 0);
            model_eval();
            @(negedge clk);
            tests++; if ({stallPC, stallID, flushEX} !== {3{e_stall}}) begin fails++; $display("FAIL rnd%0d stall got %b want %b", n, {stallPC, stallID, flushEX}, {3{e_stall}}); end
            tests++; if (fwd_rs_sel !== 3'(e_fwd_rs)) begin fails++; $display("FAIL rnd%0d fwd_rs got %0d want %0d", n, fwd_rs_sel, e_fwd_rs); end
            tests++; if (fwd_rt_sel !== 3'(e_fwd_rt)) begin fails++; $display("FAIL rnd%0d fwd_rt got %0d want %0d", n, fwd_rt_sel, e_fwd_rt); end
            tests++; if (md_busy !== e_busy) begin fails++; $display("FAIL rnd%0d md_busy got %b want %b", n, md_busy, e_busy); end
            tests++; if (stall_cnt !== 32'(e_cnt)) begin fails++; $display("FAIL rnd%0d stall_cnt got %0d want %0d", n, stall_cnt, e_cnt); end
            model_clock();
            next_cycle();
        end
        nop();
    endtask

    initial begin
        nop();
        rst_n = 1'b0;
        test_reset();
        test_load_use();
        test_alu_fwd();
        test_md();
        test_eret();
        test_flush();
        test_reset_mid();
        test_ns3();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
